// File: rtl/keypad_pkg.sv
// Shared types, constants and column-pattern helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;

  localparam logic [NUM_COLS-1:0] COL_IDLE = 4'b1111;

  // Index of the single low bit; only meaningful for one-cold patterns.
  function automatic logic [1:0] enc(input logic [NUM_COLS-1:0] pat);
    case (pat)
      4'b1110: enc = 2'd0;
      4'b1101: enc = 2'd1;
      4'b1011: enc = 2'd2;
      4'b0111: enc = 2'd3;
      default: enc = 2'd0;
    endcase
  endfunction

  function automatic logic one_cold(input logic [NUM_COLS-1:0] pat);
    case (pat)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_cold = 1'b1;
      default:                            one_cold = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scanner_col_sync.sv
// Two-flop synchronizer for the asynchronous keypad column lines; resets to idle.
module col_sync
  import keypad_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_COLS-1:0] i_col,
  output logic [NUM_COLS-1:0] o_col_s
);

  logic [NUM_COLS-1:0] r_meta;
  logic [NUM_COLS-1:0] r_sync;

  // Metastability filter: two back-to-back flops per column.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= COL_IDLE;
      r_sync <= COL_IDLE;
    end else begin
      r_meta <= i_col;
      r_sync <= r_meta;
    end
  end

  assign o_col_s = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// Row-walking keypad scanner: finds a single pressed key, debounces press and
// release, and emits one key_valid pulse per physical press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_COLS-1:0] col_in,
  output logic [NUM_ROWS-1:0] row_out,
  output logic                key_valid,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_held
);

  localparam int DW  = $clog2(SCAN_DIV);
  localparam int DBW = $clog2(DEBOUNCE_CNT);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CNT - 1);

  logic [NUM_COLS-1:0] w_col_s;

  state_t              r_state;
  logic [1:0]          r_row_idx;
  logic [NUM_ROWS-1:0] r_row_out;
  logic [DW-1:0]       r_dwell;
  logic [DBW-1:0]      r_deb;
  logic [NUM_COLS-1:0] r_col_pat;
  logic                r_key_valid;
  logic [KEY_W-1:0]    r_key_code;
  logic                r_key_held;

  col_sync u_col_sync (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_col   (col_in),
    .o_col_s (w_col_s)
  );

  // Scan/debounce FSM with all counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SCAN;
      r_row_idx   <= 2'd0;
      r_row_out   <= 4'b1110;
      r_dwell     <= '0;
      r_deb       <= '0;
      r_col_pat   <= COL_IDLE;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'h0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          if (r_dwell == DWELL_LAST) begin
            // Idle and multi-bit (ghost) patterns just move the scan on.
            if (one_cold(w_col_s)) begin
              r_col_pat <= w_col_s;
              r_deb     <= '0;
              r_state   <= ST_PRESS_DB;
            end else begin
              r_row_idx <= r_row_idx + 2'd1;
              r_row_out <= {r_row_out[NUM_ROWS-2:0], r_row_out[NUM_ROWS-1]};
              r_dwell   <= '0;
            end
          end else begin
            r_dwell <= r_dwell + DW'(1);
          end
        end
        ST_PRESS_DB: begin
          if (w_col_s == r_col_pat) begin
            if (r_deb == DEB_LAST) begin
              r_key_code  <= {r_row_idx, enc(r_col_pat)};
              r_key_valid <= 1'b1;
              r_key_held  <= 1'b1;
              r_state     <= ST_HELD;
            end else begin
              r_deb <= r_deb + DBW'(1);
            end
          end else begin
            r_dwell <= '0;
            r_state <= ST_SCAN;
          end
        end
        ST_HELD: begin
          if (w_col_s == COL_IDLE) begin
            r_deb   <= '0;
            r_state <= ST_RELEASE_DB;
          end else begin
            r_state <= ST_HELD;
          end
        end
        ST_RELEASE_DB: begin
          if (w_col_s == COL_IDLE) begin
            if (r_deb == DEB_LAST) begin
              r_key_held <= 1'b0;
              r_row_idx  <= r_row_idx + 2'd1;
              r_row_out  <= {r_row_out[NUM_ROWS-2:0], r_row_out[NUM_ROWS-1]};
              r_dwell    <= '0;
              r_state    <= ST_SCAN;
            end else begin
              r_deb <= r_deb + DBW'(1);
            end
          end else begin
            r_state <= ST_HELD;
          end
        end
        default: begin
          r_state <= ST_SCAN;
          r_dwell <= '0;
        end
      endcase
    end
  end

  assign row_out   = r_row_out;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_held  = r_key_held;

endmodule
